// File: rtl/cmd_pkg.sv
// +--------------------------------------------------------------------+
// | cmd_pkg: shared command opcodes, response constants, FSM states.   |
// | Rev 1.0; TX_CSUM state present only with CMD_RESP_CHECKSUM_EN.     |
// +--------------------------------------------------------------------+
`default_nettype none

package cmd_pkg;

  localparam logic [7:0] CMD_WRITE        = 8'h02;
  localparam logic [7:0] CMD_READ         = 8'h01;
  localparam logic [7:0] RESP_HDR_DEFAULT = 8'h03;
  localparam int         TOUT_FLAG_BIT    = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_TX_HDR  = 3'd2,
    ST_TX_ADDR = 3'd3,
`ifdef CMD_RESP_CHECKSUM_EN
    ST_TX_DATA = 3'd4,
    ST_TX_CSUM = 3'd5
`else
    ST_TX_DATA = 3'd4
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/resp_byte_tx.sv
// +--------------------------------------------------------------------+
// | resp_byte_tx: valid/ready output byte register for response bytes. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module resp_byte_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_done,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_accept
);

  logic [7:0] r_data;
  logic       r_valid;

  // Load takes priority so the next byte follows an accepted one with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_byte;
      r_valid <= 1'b1;
    end else if (i_done) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_accept = r_valid & i_ready;

endmodule

`default_nettype wire

// File: rtl/cmd_resp_tx.sv
// +--------------------------------------------------------------------+
// | cmd_resp_tx: register read + response frame serializer.            |
// | Rev 1.0; CMD_RESP_CHECKSUM_EN adds a 4th XOR checksum byte.        |
// +--------------------------------------------------------------------+
`default_nettype none

module cmd_resp_tx
  import cmd_pkg::*;
#(
  parameter logic [7:0] RESP_HDR     = RESP_HDR_DEFAULT,
  parameter int         RD_TIMEOUT   = 15,
  parameter logic [7:0] TIMEOUT_DATA = 8'hEE
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       CmdRead,
  input  logic [7:0] CmdAddr,
  output logic       RegRdEn,
  output logic [7:0] RegRdAddr,
  input  logic [7:0] RegRdData,
  input  logic       RegRdValid,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxReady,
  output logic       Busy,
  output logic       Overflow,
  input  logic       OvfClr
);

  localparam logic [7:0] c_tout_flag = 8'(1 << TOUT_FLAG_BIT);
  localparam logic [7:0] c_tout_cnt  = 8'(RD_TIMEOUT);

  state_t     r_state, w_state_nxt;
  logic       r_rd_en, w_rd_en_nxt;
  logic [7:0] r_rd_addr, w_rd_addr_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_pend_vld, w_pend_vld_nxt;
  logic [7:0] r_pend_addr, w_pend_addr_nxt;
  logic       r_ovf, w_ovf_set;
  logic       w_tx_load, w_tx_done, w_accept;
  logic [7:0] w_tx_byte;
`ifdef CMD_RESP_CHECKSUM_EN
  logic [7:0] r_csum, w_csum_nxt;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= 8'h00;
      r_cnt       <= 8'h00;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= 8'h00;
      r_ovf       <= 1'b0;
`ifdef CMD_RESP_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_ovf       <= w_ovf_set ? 1'b1 : (OvfClr ? 1'b0 : r_ovf);
`ifdef CMD_RESP_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = r_rd_addr;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_ovf_set       = 1'b0;
    w_tx_load       = 1'b0;
    w_tx_done       = 1'b0;
    w_tx_byte       = r_addr;
`ifdef CMD_RESP_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif

    case (r_state)
      ST_IDLE: begin
        // Serving the slot vacates it, so a same-cycle CmdRead refills it.
        if (r_pend_vld) begin
          w_rd_en_nxt    = 1'b1;
          w_rd_addr_nxt  = r_pend_addr;
          w_addr_nxt     = r_pend_addr;
          w_cnt_nxt      = 8'h00;
          w_pend_vld_nxt = CmdRead;
          if (CmdRead) w_pend_addr_nxt = CmdAddr;
          w_state_nxt    = ST_RD_WAIT;
        end else if (CmdRead) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = CmdAddr;
          w_addr_nxt    = CmdAddr;
          w_cnt_nxt     = 8'h00;
          w_state_nxt   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // The strobe cycle itself cannot carry read data.
        if (!r_rd_en && RegRdValid) begin
          w_data_nxt  = RegRdData;
          w_tx_load   = 1'b1;
          w_tx_byte   = RESP_HDR;
          w_state_nxt = ST_TX_HDR;
`ifdef CMD_RESP_CHECKSUM_EN
          w_csum_nxt  = RESP_HDR ^ r_addr ^ RegRdData;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 8'h01;
          if (w_cnt_nxt == c_tout_cnt) begin
            w_data_nxt  = TIMEOUT_DATA;
            w_tx_load   = 1'b1;
            w_tx_byte   = RESP_HDR | c_tout_flag;
            w_state_nxt = ST_TX_HDR;
`ifdef CMD_RESP_CHECKSUM_EN
            w_csum_nxt  = (RESP_HDR | c_tout_flag) ^ r_addr ^ TIMEOUT_DATA;
`endif
          end
        end
      end
      ST_TX_HDR: begin
        if (w_accept) begin
          w_tx_load   = 1'b1;
          w_tx_byte   = r_addr;
          w_state_nxt = ST_TX_ADDR;
        end
      end
      ST_TX_ADDR: begin
        if (w_accept) begin
          w_tx_load   = 1'b1;
          w_tx_byte   = r_data;
          w_state_nxt = ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        if (w_accept) begin
`ifdef CMD_RESP_CHECKSUM_EN
          w_tx_load   = 1'b1;
          w_tx_byte   = r_csum;
          w_state_nxt = ST_TX_CSUM;
`else
          w_tx_done   = 1'b1;
          w_state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef CMD_RESP_CHECKSUM_EN
      ST_TX_CSUM: begin
        if (w_accept) begin
          w_tx_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    if (r_state != ST_IDLE && CmdRead) begin
      if (!r_pend_vld) begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_addr_nxt = CmdAddr;
      end else begin
        w_ovf_set = 1'b1;
      end
    end
  end

  resp_byte_tx u_byte_tx (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .i_load   (w_tx_load),
    .i_byte   (w_tx_byte),
    .i_done   (w_tx_done),
    .i_ready  (TxReady),
    .o_data   (TxData),
    .o_valid  (TxValid),
    .o_accept (w_accept)
  );

  assign RegRdEn   = r_rd_en;
  assign RegRdAddr = r_rd_addr;
  assign Busy      = (r_state != ST_IDLE);
  assign Overflow  = r_ovf;

endmodule

`default_nettype wire

// File: doc/cmd_resp_tx.md
Name: cmd_resp_tx

Overview:
- Return path of the host command channel: turns decoded read commands into register reads and serializes the result as a response frame of 3 bytes, or 4 bytes with the optional checksum.
- Sits between the command decoder (CmdRead/CmdAddr) and the register file read port on one side, and the byte transmitter (UART TX) on the other, using a valid/ready byte handshake.

Parameters:
- RESP_HDR, 8'h03, response header byte; bit 7 must be 0, because bit 7 is reserved as the timeout flag.
- RD_TIMEOUT, 15, cycles to wait for RegRdValid before aborting; legal range 1..255.
- TIMEOUT_DATA, 8'hEE, data byte sent when a read times out.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- CmdRead  in  1  one-cycle read request strobe from the command decoder.
- CmdAddr  in  8  register address, valid with CmdRead.
- RegRdEn  out  1  one-cycle register read strobe.
- RegRdAddr  out  8  register read address, valid with RegRdEn.
- RegRdData  in  8  read data, valid with RegRdValid.
- RegRdValid  in  1  read data valid; arrives 1..N cycles after RegRdEn.
- TxData  out  8  response byte.
- TxValid  out  1  TxData valid.
- TxReady  in  1  transmitter accepts the byte when TxValid and TxReady are both high at a rising edge.
- Busy  out  1  high whenever the state is not IDLE.
- Overflow  out  1  sticky flag: a request was dropped.
- OvfClr  in  1  clears Overflow.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, RegRdEn=0, RegRdAddr=0, TxValid=0, TxData=0, Busy=0, Overflow=0, pending slot empty, timeout counter=0.
- Reset mid-frame aborts the frame. No partial byte is retried.
- States: IDLE, RD_WAIT, TX_HDR, TX_ADDR, TX_DATA, TX_CSUM (TX_CSUM exists only with the optional feature).
- IDLE:
  - If the pending slot is full, serve it first; else serve CmdRead if high.
  - Serving a request: RegRdEn<=1 for exactly one cycle, RegRdAddr<=addr, address latched, counter<=0, go to RD_WAIT.
- RD_WAIT:
  - RegRdEn<=0. RegRdValid is sampled from the cycle after RegRdEn onward.
  - On RegRdValid: latch RegRdData, TxData<=RESP_HDR, TxValid<=1, go to TX_HDR.
  - Otherwise the counter increments. When the counter reaches RD_TIMEOUT without RegRdValid, the data byte is TIMEOUT_DATA, TxData<=RESP_HDR|8'h80, and the state goes to TX_HDR.
  - A RegRdValid arriving late, after the timeout, is ignored.
- TX_x states:
  - TxData and TxValid are held stable until TxReady is sampled high.
  - On acceptance, the next byte is loaded in the same edge (back-to-back, no bubble): HDR -> addr -> data -> (csum) -> IDLE.
  - TxValid<=0 when the last byte is accepted.
- Latency: CmdRead at cycle 0 -> RegRdEn at cycle 1. With RegRdValid at cycle 2 and TxReady held high, header at cycles 3..3, addr at cycle 4, data at cycle 5, and IDLE at cycle 6.
- Pending slot (one deep):
  - CmdRead while not IDLE, or in the IDLE cycle that serves the pending slot, stores the request into the slot if it is empty.
  - If the slot is full, the request is dropped and Overflow<=1.
- OvfClr clears Overflow; set and clear in the same cycle -> set wins.
- CmdRead while Rst_n is low is ignored.
- Write commands produce no response.

Optional Feature:
- Macro CMD_RESP_CHECKSUM_EN.
- Defined: a 4th byte, TX_CSUM, follows data. Its value is the XOR of the header (including the timeout bit), addr and data.
- Undefined: 3-byte frame; TX_DATA acceptance returns to IDLE; no checksum logic is present.

Decomposition:
- Shared package cmd_pkg holds:
  - command opcodes: CMD_WRITE=8'h02, CMD_READ=8'h01;
  - RESP_HDR default and the timeout flag bit position;
  - the state enumeration constants.
- One sub-module is natural: resp_byte_tx, the valid/ready output register holding TxData/TxValid with its load/accept logic.
- The FSM, pending slot and timeout counter stay in cmd_resp_tx.

Test Plan:
- Basic read: CmdRead, addr 8'h10; RegRdValid 1 cycle after RegRdEn with data 8'hA5; TxReady=1 -> bytes 03,10,A5 on consecutive cycles; with the macro defined, a 4th byte B6.
- Backpressure: TxReady low for 5 cycles during the addr byte -> TxData stays 8'h10 with TxValid high throughout; exactly one transfer per byte; frame completes intact.
- Timeout: RegRdValid never asserted, RD_TIMEOUT=15 -> frame 83,addr,EE; a later RegRdValid pulse produces no extra bytes.
- Queueing: CmdRead addr 01, then CmdRead addr 02 while busy -> two frames in order (01 then 02); Overflow stays 0.
- Overflow: three CmdReads while busy -> 2nd queued, 3rd dropped, Overflow=1. OvfClr and a fresh drop in the same cycle -> Overflow remains 1. OvfClr alone -> Overflow=0.
- Reset mid-frame: Rst_n low during TX_ADDR -> TxValid=0, Busy=0 and the pending slot empty immediately (asynchronously). A new CmdRead after release -> clean frame.
